// File: rtl/phy_rx_destripe.sv
// ============================================================================
// Module   : phy_rx_destripe
// Purpose  : 4-lane PHY receive de-striper; COM-based alignment and
//            registered lane-word reassembly. Optional PHY_RX_ERR_CNT_EN
//            adds a saturating err_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx_destripe #(
  parameter logic [7:0] COM_SYM   = 8'hBC,
  parameter logic [7:0] SKP_SYM   = 8'h1C,
  parameter logic [7:0] PAD_SYM   = 8'hF7,
  parameter int         LOCK_COMS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       k_in,
  input  logic       valid_in,
  output logic [7:0] Out0,
  output logic [7:0] Out1,
  output logic [7:0] Out2,
  output logic [7:0] Out3,
  output logic       valid0,
  output logic       valid1,
  output logic       valid2,
  output logic       valid3,
  output logic       group_strobe,
  output logic       locked,
  output logic       align_err
`ifdef PHY_RX_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [3:0] c_LOCK = 4'(LOCK_COMS);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_slot;
  logic [3:0] r_com_cnt;
  logic [7:0] r_sh0, r_sh1, r_sh2;
  logic [2:0] r_shv;

  logic       w_is_com;
  logic       w_is_skp;
  logic       w_is_fill;
  logic       w_fill_v;
  logic [3:0] w_com_inc;
  logic       w_err_evt;

  assign w_is_com  = valid_in && k_in && (data_in == COM_SYM);
  assign w_is_skp  = valid_in && k_in && (data_in == SKP_SYM);
  // PAD_SYM and any unrecognised K-character both occupy a slot as invalid.
  assign w_is_fill = valid_in && !w_is_com && !w_is_skp;
  assign w_fill_v  = !k_in;
  assign w_com_inc = (r_com_cnt >= c_LOCK) ? c_LOCK : r_com_cnt + 4'd1;
  assign w_err_evt = w_is_com && (r_slot != 2'd0) &&
                     ((r_state == ST_ALIGN) || (r_state == ST_LOCKED));
  assign locked    = (r_state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_SEARCH;
      r_slot       <= 2'd0;
      r_com_cnt    <= 4'd0;
      r_sh0        <= 8'h00;
      r_sh1        <= 8'h00;
      r_sh2        <= 8'h00;
      r_shv        <= 3'b000;
      Out0         <= 8'h00;
      Out1         <= 8'h00;
      Out2         <= 8'h00;
      Out3         <= 8'h00;
      valid0       <= 1'b0;
      valid1       <= 1'b0;
      valid2       <= 1'b0;
      valid3       <= 1'b0;
      group_strobe <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      group_strobe <= 1'b0;
      align_err    <= 1'b0;
      if (w_is_com) begin
        case (r_state)
          ST_SEARCH: begin
            r_com_cnt <= 4'd1;
            r_slot    <= 2'd0;
            r_state   <= (c_LOCK == 4'd1) ? ST_LOCKED : ST_ALIGN;
          end
          ST_ALIGN: begin
            if (r_slot == 2'd0) begin
              r_com_cnt <= w_com_inc;
              if (w_com_inc == c_LOCK) r_state <= ST_LOCKED;
            end else begin
              r_state   <= ST_SEARCH;
              r_com_cnt <= 4'd0;
              r_slot    <= 2'd0;
            end
          end
          ST_LOCKED: begin
            if (r_slot != 2'd0) begin
              align_err <= 1'b1;
              r_state   <= ST_ALIGN;
              r_com_cnt <= 4'd1;
              r_slot    <= 2'd0;
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end else if (w_is_fill && (r_state != ST_SEARCH)) begin
        r_slot <= r_slot + 2'd1;
        case (r_slot)
          2'd0: begin r_sh0 <= data_in; r_shv[0] <= w_fill_v; end
          2'd1: begin r_sh1 <= data_in; r_shv[1] <= w_fill_v; end
          2'd2: begin r_sh2 <= data_in; r_shv[2] <= w_fill_v; end
          default: begin
            // Slot 3 bypasses the shadow straight into the output word.
            if (r_state == ST_LOCKED) begin
              Out0         <= r_sh0;
              Out1         <= r_sh1;
              Out2         <= r_sh2;
              Out3         <= data_in;
              valid0       <= r_shv[0];
              valid1       <= r_shv[1];
              valid2       <= r_shv[2];
              valid3       <= w_fill_v;
              group_strobe <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef PHY_RX_ERR_CNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err_count <= 8'h00;
    end else if (w_err_evt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_err;
  assign w_unused_err = w_err_evt;
`endif

endmodule

`default_nettype wire
